// File: rtl/input_pixel_serializer.sv
// Pops 24-bit RGB pixels from the input FIFO and streams them as tagged 8-bit
// channel bytes (R, G, B) over valid/ready, framing a fixed IMG_W x IMG_H image.
module input_pixel_serializer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [23:0]   fifo_data,
  input  logic [3:0]    fifo_count,
  output logic          fifo_pop,
  output logic [7:0]    ch_data,
  output logic [1:0]    ch_id,
  output logic          ch_valid,
  input  logic          ch_ready,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t        r_state;
  logic [23:0]   r_pix;
  logic [7:0]    r_ch_data;
  logic [1:0]    r_ch_id;
  logic          r_ch_valid;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_busy;
  logic          r_frame_done;

  logic          w_fifo_nonempty;
  logic          w_accept;
  logic          w_pix_end;
  logic          w_last_pix;
  logic          w_col_wrap;
  logic          w_pop;
  logic          w_last;

  // Channel byte of a pixel, R first.
  function automatic logic [7:0] sel_byte(input logic [23:0] pix, input logic [1:0] id);
    case (id)
      2'd0:    return pix[23:16];
      2'd1:    return pix[15:8];
      default: return pix[7:0];
    endcase
  endfunction

  assign w_fifo_nonempty = (fifo_count != 4'd0);
  assign w_accept        = r_ch_valid & ch_ready;
  assign w_pix_end       = w_accept & (r_ch_id == 2'd2);
  assign w_last_pix      = (r_col == COL_MAX) && (r_row == ROW_MAX);
  assign w_col_wrap      = (r_col == COL_MAX);

  // Pop strobe must reach the FIFO in the same cycle, so it stays combinational.
  always_comb begin
    w_pop  = 1'b0;
    w_last = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: w_pop = w_fifo_nonempty;
        S_EMIT: begin
          w_pop  = w_pix_end & ~w_last_pix & w_fifo_nonempty;
          w_last = (r_ch_id == 2'd2) & w_last_pix;
        end
        default: begin
          w_pop  = 1'b0;
          w_last = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pix        <= '0;
      r_ch_data    <= '0;
      r_ch_id      <= '0;
      r_ch_valid   <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_pop) begin
            r_pix      <= fifo_data;
            r_ch_data  <= fifo_data[23:16];
            r_ch_id    <= 2'd0;
            r_ch_valid <= 1'b1;
            r_state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            if (r_ch_id != 2'd2) begin
              r_ch_id   <= r_ch_id + 2'd1;
              r_ch_data <= sel_byte(r_pix, r_ch_id + 2'd1);
            end else if (w_last_pix) begin
              r_ch_valid   <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_col <= w_col_wrap ? '0 : r_col + CW'(1);
              r_row <= w_col_wrap ? r_row + RW'(1) : r_row;
              // Back-to-back load keeps one byte per cycle across pixel boundaries.
              if (w_pop) begin
                r_pix     <= fifo_data;
                r_ch_data <= fifo_data[23:16];
                r_ch_id   <= 2'd0;
              end else begin
                r_ch_valid <= 1'b0;
                r_state    <= S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_pop   = w_pop;
  assign last       = w_last;
  assign ch_data    = r_ch_data;
  assign ch_id      = r_ch_id;
  assign ch_valid   = r_ch_valid;
  assign col        = r_col;
  assign row        = r_row;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_input_pixel_serializer.sv
// Directed bench for input_pixel_serializer: a 4x2 instance for framing and
// backpressure, an 8x2 instance for the mid-row FIFO underrun case.
module tb_input_pixel_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b, ch_ready;
  logic [23:0] fifo_data;
  logic [3:0]  fifo_count;

  logic       pop_a, valid_a, last_a, busy_a, done_a;
  logic [7:0] data_a;
  logic [1:0] id_a;
  logic [1:0] col_a;
  logic [0:0] row_a;

  logic       pop_b, valid_b, last_b, busy_b, done_b;
  logic [7:0] data_b;
  logic [1:0] id_b;
  logic [2:0] col_b;
  logic [0:0] row_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_pixel_serializer #(.IMG_W(4), .IMG_H(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_pop(pop_a),
    .ch_data(data_a), .ch_id(id_a), .ch_valid(valid_a), .ch_ready(ch_ready),
    .col(col_a), .row(row_a), .last(last_a), .busy(busy_a), .frame_done(done_a)
  );

  input_pixel_serializer #(.IMG_W(8), .IMG_H(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_pop(pop_b),
    .ch_data(data_b), .ch_id(id_b), .ch_valid(valid_b), .ch_ready(ch_ready),
    .col(col_b), .row(row_b), .last(last_b), .busy(busy_b), .frame_done(done_b)
  );

  // Show-ahead FIFO model: writer pointer owned by the stimulus, reader by the pop strobe.
  logic [23:0] mem [64];
  logic [5:0]  wp = '0;
  logic [5:0]  rp = '0;
  int          pop_empty = 0;

  assign fifo_count = 4'(wp - rp);
  assign fifo_data  = mem[rp];

  always @(posedge clk) begin
    if (pop_a || pop_b) begin
      if (wp == rp) pop_empty <= pop_empty + 1;
      else          rp <= rp + 6'd1;
    end
  end

  task automatic push(input logic [23:0] px);
    mem[wp] = px;
    wp = wp + 6'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    tick();
    tick();
    wp = rp;
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic        start;
    logic        ready;
    logic        push;
    logic [23:0] pix;
  } vin_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic [1:0] id;
    logic [1:0] col;
    logic       row;
    logic       pop;
    logic       last;
    logic       busy;
    logic       done;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic rd, input logic ps, input logic [23:0] px,
                              input logic vl, input logic [7:0] dt, input logic [1:0] id,
                              input logic [1:0] cl, input logic rw, input logic pp,
                              input logic ls, input logic by, input logic dn);
    return {st, rd, ps, px, vl, dt, id, cl, rw, pp, ls, by, dn};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vout_t act_o, exp_o;
    int nb, nbytes, pulses, done_cyc;
    bit found;

    //               st    rd    ps    pix           vl    data   id    col   row   pop   last  busy  done
    vecs[0]  = mk(1'b1, 1'b1, 1'b1, 24'h384758, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h38, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h47, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h58, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 24'h253267, 1'b0, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h25, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 24'h112233, 1'b1, 8'h32, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 8'h32, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 8'h32, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 8'h32, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 8'h32, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h32, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h67, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h11, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h22, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 8'h33, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 8'h00, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ch_ready = 1'b0;
    tick();
    apply_reset();
    #1;
    check("reset_state", 32'({valid_a, data_a, id_a, col_a, row_a, pop_a, last_a, busy_a, done_a}), 32'd0);
    tick();

    // Single pixel, backpressure, and back-to-back pixel load.
    for (int k = 0; k < NV; k++) begin
      start_a  = vecs[k].i.start;
      ch_ready = vecs[k].i.ready;
      if (vecs[k].i.push) push(vecs[k].i.pix);
      #1;
      exp_o = vecs[k].o;
      act_o = {valid_a, data_a, id_a, col_a, row_a, pop_a, last_a, busy_a, done_a};
      if (!exp_o.valid) begin
        act_o.data = '0;
        act_o.id   = '0;
        exp_o.data = '0;
        exp_o.id   = '0;
      end
      n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL vec%0d: got %h expected %h", k, act_o, exp_o);
      end
      tick();
    end

    // Reset while emitting ch_id 1 of the second pixel.
    apply_reset();
    push(24'h102030);
    push(24'h405060);
    start_a  = 1'b1;
    ch_ready = 1'b1;
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (valid_a && id_a == 2'd1 && col_a == 2'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_mid_pixel", 32'(found), 32'd1);
    check("mid_pixel_data", 32'(data_a), 32'h50);
    reset = 1'b1;
    push(24'h778899);
    tick();
    reset = 1'b0;
    #1;
    check("reset_mid_outputs", 32'({valid_a, data_a, id_a, col_a, row_a, pop_a, last_a, busy_a, done_a}), 32'd0);
    tick();
    wp = rp;
    push(24'hD4E5F6);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    #1;
    check("restart_busy", 32'(busy_a), 32'd1);
    check("restart_pop", 32'(pop_a), 32'd1);
    tick();
    #1;
    check("restart_first", 32'({valid_a, data_a, id_a, col_a, row_a}), 32'({1'b1, 8'hD4, 2'd0, 2'd0, 1'b0}));
    tick();

    // FIFO underrun after pixel 3 on the 8-wide instance.
    apply_reset();
    push(24'h010203);
    push(24'h040506);
    push(24'h070809);
    push(24'h0A0B0C);
    start_b  = 1'b1;
    ch_ready = 1'b1;
    tick();
    start_b = 1'b0;
    nb = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (valid_b && ch_ready) nb++;
      tick();
      if (nb == 12) break;
    end
    check("underrun_bytes", 32'(nb), 32'd12);
    #1;
    check("underrun_fetch", 32'({valid_b, busy_b, col_b, row_b}), 32'({1'b0, 1'b1, 3'd4, 1'b0}));
    tick();
    #1;
    check("underrun_wait_valid", 32'(valid_b), 32'd0);
    push(24'hCAFE01);
    #1;
    check("underrun_pop", 32'(pop_b), 32'd1);
    tick();
    #1;
    check("underrun_resume", 32'({valid_b, data_b, id_b, col_b, row_b}), 32'({1'b1, 8'hCA, 2'd0, 3'd4, 1'b0}));

    // Full 4x2 frame, stray start mid-frame, restart straight after frame_done.
    apply_reset();
    for (int p = 0; p < 8; p++) push({8'(3 * p + 1), 8'(3 * p + 2), 8'(3 * p + 3)});
    start_a  = 1'b1;
    ch_ready = 1'b1;
    tick();
    nbytes = 0;
    pulses = 0;
    done_cyc = -1;
    for (int c = 1; c <= 27; c++) begin
      start_a = (c == 10) || (c == 27);
      if (c == 26) push(24'h9ABCDE);
      #1;
      if (valid_a) begin
        nbytes++;
        check("frame_data", 32'(data_a), 32'(nbytes));
        check("frame_id", 32'(id_a), 32'((nbytes - 1) % 3));
        check("frame_col", 32'(col_a), 32'(((nbytes - 1) / 3) % 4));
        check("frame_row", 32'(row_a), 32'((nbytes - 1) / 12));
        check("frame_last", 32'(last_a), 32'(nbytes == 24));
      end
      if (done_a) begin
        pulses++;
        done_cyc = c;
      end
      if (c == 27) begin
        check("frame_idle_after", 32'({busy_a, col_a, row_a}), 32'({1'b0, 2'd3, 1'b0 + 1'b1}));
      end
      tick();
    end
    start_a = 1'b0;
    check("frame_byte_count", 32'(nbytes), 32'd24);
    check("frame_done_pulses", 32'(pulses), 32'd1);
    check("frame_done_cycle", 32'(done_cyc), 32'd26);
    #1;
    check("frame2_fetch", 32'({busy_a, pop_a}), 32'({1'b1, 1'b1}));
    tick();
    #1;
    check("frame2_first", 32'({valid_a, data_a, id_a, col_a, row_a}), 32'({1'b1, 8'h9A, 2'd0, 2'd0, 1'b0}));
    tick();

    check("pop_when_empty", 32'(pop_empty), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
